// File: rtl/irq_controller.sv
// Prioritised interrupt controller: edge capture, CPU mask, fixed priority, REQ/SERVICE handshake.
// Edge->irq 2 cycles, ack->irq low 1 cycle; IRQ_CONTROLLER_LEVEL_EN selects level-sensitive sources.
module irq_controller #(
   parameter int N_SRC = 4,
   parameter int VEC_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_SRC-1:0] src_irq,
   input  logic [1:0]       reg_sel,
   input  logic             reg_we,
   input  logic [15:0]      reg_wdata,
   output logic [15:0]      reg_rdata,
   output logic             irq,
   input  logic             irq_ack,
   output logic [VEC_W-1:0] vector,
   output logic             in_service
);

   localparam logic [1:0] SEL_PEND = 2'd0;
   localparam logic [1:0] SEL_MASK = 2'd1;
   localparam logic [1:0] SEL_VEC  = 2'd2;
   localparam logic [1:0] SEL_EOI  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [N_SRC-1:0] pending, pending_nxt;
   logic [N_SRC-1:0] mask;
   logic [N_SRC-1:0] eligible;
   logic [VEC_W-1:0] sel, vector_nxt;
   logic             ack_take;
   logic             eoi_wr;
   logic             mask_wr;
   logic [16:0]      unused_bits;

   assign unused_bits = {ack_take, reg_wdata};

   assign eligible = pending & mask;
   assign eoi_wr   = reg_we && (reg_sel == SEL_EOI);
   assign mask_wr  = reg_we && (reg_sel == SEL_MASK);

   always_comb begin
      sel = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) sel = VEC_W'(i);
      end
   end

   always_comb begin
      state_nxt  = state;
      vector_nxt = vector;
      ack_take   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|eligible) begin
               state_nxt  = ST_REQ;
               vector_nxt = sel;
            end
         end
         ST_REQ: begin
            // Losing every eligible source withdraws the request before any ack is honoured.
            if (!(|eligible)) begin
               state_nxt = ST_IDLE;
            end else if (irq_ack) begin
               ack_take  = 1'b1;
               state_nxt = ST_SERVICE;
            end else begin
               vector_nxt = sel;
            end
         end
         ST_SERVICE: begin
            if (eoi_wr) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef IRQ_CONTROLLER_LEVEL_EN
   always_comb begin
      pending_nxt = src_irq;
   end
`else
   logic [N_SRC-1:0] prev;
   logic [N_SRC-1:0] w1c_clr;
   logic [N_SRC-1:0] ack_clr;

   always_comb begin
      w1c_clr = '0;
      if (reg_we && (reg_sel == SEL_PEND)) w1c_clr = reg_wdata[N_SRC-1:0];
      for (int i = 0; i < N_SRC; i++) begin
         ack_clr[i] = ack_take && (vector == VEC_W'(i));
      end
      // A fresh edge overrides a same-cycle clear of that bit.
      pending_nxt = (pending & ~(w1c_clr | ack_clr)) | (src_irq & ~prev);
   end

   always_ff @(posedge clock) begin
      if (reset) prev <= '0;
      else       prev <= src_irq;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= ST_IDLE;
         vector  <= '0;
         mask    <= '0;
         pending <= '0;
      end else begin
         state   <= state_nxt;
         vector  <= vector_nxt;
         pending <= pending_nxt;
         if (mask_wr) mask <= reg_wdata[N_SRC-1:0];
      end
   end

   assign irq        = (state == ST_REQ);
   assign in_service = (state == ST_SERVICE);

   always_comb begin
      reg_rdata = '0;
      case (reg_sel)
         SEL_PEND: reg_rdata[N_SRC-1:0] = pending;
         SEL_MASK: reg_rdata[N_SRC-1:0] = mask;
         SEL_VEC: begin
            reg_rdata[15]        = in_service;
            reg_rdata[VEC_W-1:0] = vector;
         end
         default: reg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_irq_controller.sv
// Randomised and directed bench for irq_controller against a rule-level reference model.
module tb_irq_controller;

   localparam int N     = 4;
   localparam int VW    = 4;
   localparam logic [1:0] PEND = 2'd0;
   localparam logic [1:0] MASK = 2'd1;
   localparam logic [1:0] VEC  = 2'd2;
   localparam logic [1:0] EOI  = 2'd3;
   localparam bit [15:0] NMASK = 16'((1 << N) - 1);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [N-1:0]  src_irq = '0;
   logic [1:0]    reg_sel = '0;
   logic          reg_we = 1'b0;
   logic [15:0]   reg_wdata = '0;
   logic [15:0]   reg_rdata;
   logic          irq;
   logic          irq_ack = 1'b0;
   logic [VW-1:0] vector;
   logic          in_service;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: pending/mask as bit sets, two booleans for "requesting" and "in service".
   bit [15:0] m_pend, m_mask, m_prev;
   bit        m_req, m_svc;
   int        m_vec;

   irq_controller #(.N_SRC(N), .VEC_W(VW)) dut (
      .clock      (clock),
      .reset      (reset),
      .src_irq    (src_irq),
      .reg_sel    (reg_sel),
      .reg_we     (reg_we),
      .reg_wdata  (reg_wdata),
      .reg_rdata  (reg_rdata),
      .irq        (irq),
      .irq_ack    (irq_ack),
      .vector     (vector),
      .in_service (in_service)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%h expected 0x%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input bit [15:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '0; m_prev = '0;
      m_req = 1'b0; m_svc = 1'b0; m_vec = 0;
   endtask

   task automatic model_step(input bit rst, input bit [15:0] src, input bit ack,
                             input bit we, input bit [1:0] sel, input bit [15:0] wd);
      bit [15:0] clr;
      int        first;
      if (rst) begin
         model_reset();
         return;
      end
      first = lowest(m_pend & m_mask);
      clr   = '0;
      if (we && sel == PEND) clr = wd & NMASK;
      if (m_svc) begin
         if (we && sel == EOI) m_svc = 1'b0;
      end else if (m_req) begin
         if (first < 0) m_req = 1'b0;
         else if (ack) begin
`ifndef IRQ_CONTROLLER_LEVEL_EN
            clr[m_vec] = 1'b1;
`endif
            m_req = 1'b0;
            m_svc = 1'b1;
         end else m_vec = first;
      end else if (first >= 0) begin
         m_req = 1'b1;
         m_vec = first;
      end
`ifdef IRQ_CONTROLLER_LEVEL_EN
      m_pend = src & NMASK;
`else
      m_pend = (m_pend & ~clr) | (src & ~m_prev & NMASK);
`endif
      m_prev = src & NMASK;
      if (we && sel == MASK) m_mask = wd & NMASK;
   endtask

   function automatic bit [15:0] model_rdata(input bit [1:0] sel);
      case (sel)
         PEND:    return m_pend;
         MASK:    return m_mask;
         VEC:     return {m_svc, 15'(m_vec)};
         default: return 16'h0;
      endcase
   endfunction

   // One clock: drive at negedge, compare against the model, then advance the model.
   task automatic apply(input logic rst, input logic [N-1:0] src, input logic ack,
                        input logic we, input logic [1:0] sel, input logic [15:0] wd);
      @(negedge clock);
      reset = rst; src_irq = src; irq_ack = ack;
      reg_we = we; reg_sel = sel; reg_wdata = wd;
      #1;
      chk("irq", 16'(irq), 16'(m_req));
      chk("in_service", 16'(in_service), 16'(m_svc));
      chk("vector", 16'(vector), 16'(m_vec));
      chk("rdata", reg_rdata, model_rdata(sel));
      model_step(rst, 16'(src), ack, we, sel, wd);
   endtask

   task automatic idle(input int n, input logic [N-1:0] src);
      for (int k = 0; k < n; k++) apply(1'b0, src, 1'b0, 1'b0, PEND, 16'h0);
   endtask

   initial begin
      repeat (2) @(posedge clock);
      model_reset();
      apply(1'b0, '0, 1'b0, 1'b0, PEND, 16'h0);
      chk("reset_irq", 16'(irq), 16'h0);
      chk("reset_pend", reg_rdata, 16'h0);

`ifndef IRQ_CONTROLLER_LEVEL_EN
      // Basic request / ack / EOI
      apply(1'b0, '0, 1'b0, 1'b1, MASK, 16'h0003);
      apply(1'b0, 4'b0010, 1'b0, 1'b0, PEND, 16'h0);
      idle(2, '0);
      chk("tp1_irq", 16'(irq), 16'h1);
      chk("tp1_vec", 16'(vector), 16'h1);
      apply(1'b0, '0, 1'b1, 1'b0, PEND, 16'h0);
      apply(1'b0, '0, 1'b0, 1'b0, PEND, 16'h0);
      chk("tp1_ack_irq", 16'(irq), 16'h0);
      chk("tp1_insvc", 16'(in_service), 16'h1);
      chk("tp1_pend", reg_rdata, 16'h0);
      apply(1'b0, '0, 1'b0, 1'b1, EOI, 16'h0);
      idle(1, '0);
      chk("tp1_eoi", 16'(in_service), 16'h0);

      // Masked source, then enabled
      apply(1'b0, '0, 1'b0, 1'b1, MASK, 16'h0001);
      apply(1'b0, 4'b0100, 1'b0, 1'b0, PEND, 16'h0);
      idle(2, '0);
      chk("tp2_masked_irq", 16'(irq), 16'h0);
      chk("tp2_pend", reg_rdata, 16'h0004);
      apply(1'b0, '0, 1'b0, 1'b1, MASK, 16'h0005);
      idle(2, '0);
      chk("tp2_irq", 16'(irq), 16'h1);
      chk("tp2_vec", 16'(vector), 16'h2);

      // Pre-emption before ack
      apply(1'b0, 4'b0001, 1'b0, 1'b0, PEND, 16'h0);
      idle(2, '0);
      chk("tp3_vec", 16'(vector), 16'h0);
      apply(1'b0, '0, 1'b1, 1'b0, PEND, 16'h0);
      idle(1, '0);
      chk("tp3_pend", reg_rdata, 16'h0004);
      apply(1'b0, '0, 1'b0, 1'b1, EOI, 16'h0);
      idle(2, '0);
      chk("tp3_irq", 16'(irq), 16'h1);
      chk("tp3_vec2", 16'(vector), 16'h2);

      // Edge in SERVICE with same-cycle W1C of that bit
      apply(1'b0, '0, 1'b1, 1'b0, PEND, 16'h0);
      apply(1'b0, 4'b0001, 1'b0, 1'b1, PEND, 16'h0001);
      idle(1, '0);
      chk("tp4_pend", reg_rdata, 16'h0001);
      chk("tp4_irq", 16'(irq), 16'h0);
      apply(1'b0, '0, 1'b0, 1'b1, EOI, 16'h0);
      idle(2, '0);
      chk("tp4_irq_eoi", 16'(irq), 16'h1);
      chk("tp4_vec", 16'(vector), 16'h0);
      apply(1'b0, '0, 1'b1, 1'b0, PEND, 16'h0);
      apply(1'b0, '0, 1'b0, 1'b1, EOI, 16'h0);

      // Stray ack in IDLE, EOI in REQ, reset in REQ
      apply(1'b0, '0, 1'b1, 1'b0, PEND, 16'h0);
      idle(1, '0);
      chk("tp5_stray", 16'(irq), 16'h0);
      apply(1'b0, 4'b0100, 1'b0, 1'b0, PEND, 16'h0);
      idle(2, '0);
      apply(1'b0, '0, 1'b0, 1'b1, EOI, 16'h0);
      idle(1, '0);
      chk("tp5_eoi_req", 16'(irq), 16'h1);
      chk("tp5_eoi_vec", 16'(vector), 16'h2);
      apply(1'b1, '0, 1'b0, 1'b0, PEND, 16'h0);
      apply(1'b0, '0, 1'b0, 1'b0, MASK, 16'h0);
      chk("tp5_rst_irq", 16'(irq), 16'h0);
      chk("tp5_rst_mask", reg_rdata, 16'h0);
`else
      // Level-sensitive source re-requests after EOI while still high
      apply(1'b0, 4'b1000, 1'b0, 1'b1, MASK, 16'h0008);
      idle(2, 4'b1000);
      chk("lvl_irq", 16'(irq), 16'h1);
      chk("lvl_vec", 16'(vector), 16'h3);
      apply(1'b0, 4'b1000, 1'b1, 1'b0, PEND, 16'h0);
      apply(1'b0, 4'b1000, 1'b0, 1'b1, EOI, 16'h0);
      idle(2, 4'b1000);
      chk("lvl_reirq", 16'(irq), 16'h1);
      chk("lvl_revec", 16'(vector), 16'h3);
      apply(1'b0, 4'b1000, 1'b1, 1'b0, PEND, 16'h0);
      apply(1'b0, '0, 1'b0, 1'b1, EOI, 16'h0);
      idle(3, '0);
      chk("lvl_drop", 16'(irq), 16'h0);
`endif

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         logic          r_rst, r_ack, r_we;
         logic [N-1:0]  r_src;
         r_rst = ($urandom_range(0, 299) == 0);
         r_ack = ($urandom_range(0, 2) == 0);
         r_we  = ($urandom_range(0, 5) == 0);
         r_src = N'($urandom & $urandom);
         apply(r_rst, r_src, r_ack, r_we, 2'($urandom_range(0, 3)), 16'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised interrupt controller between the I/O drivers (keyboard, VGA, future peripherals) and the CPU core.
- Captures per-source interrupt events, applies a CPU-writable mask, and presents a single `irq` line plus vector to the controlpath.
- Sequences the request/acknowledge/end-of-interrupt handshake so only one interrupt is in service at a time.
- CPU access is through a small memory-mapped register window driven by the datapath.

Parameters:
- N_SRC, 4, number of interrupt sources (1..16); source 0 is highest priority.
- VEC_W, 4, width of vector field; must satisfy 2**VEC_W >= N_SRC.

Ports:
- clock  in  1  system clock (the CPU clock domain).
- reset  in  1  synchronous, active-high reset.
- src_irq  in  N_SRC  raw interrupt lines from drivers, synchronous to clock.
- reg_sel  in  2  register select: 0 = PEND, 1 = MASK, 2 = VEC, 3 = EOI.
- reg_we  in  1  write strobe for the selected register.
- reg_wdata  in  16  write data.
- reg_rdata  out  16  read data for the selected register (combinational).
- irq  out  1  interrupt request to the controlpath.
- irq_ack  in  1  single-cycle pulse from the controlpath when it takes the interrupt (its reset_irq).
- vector  out  VEC_W  index of the source currently requested or in service.
- in_service  out  1  high from acknowledge until EOI.

Behaviour:
- Reset: pending = 0, mask = 0 (all disabled), state = IDLE, irq = 0, vector = 0, in_service = 0, src_irq history = 0.
- Edge capture: each source has a prev register.
  - pending[i] is set on the cycle after src_irq[i] goes 0->1.
  - The edge is captured regardless of mask.
- Eligibility and priority:
  - eligible = pending & mask.
  - sel = lowest set index of eligible (fixed priority).
- State machine, states IDLE, REQ, SERVICE:
  - IDLE: if eligible != 0, go to REQ next cycle and register vector = sel. irq = 0.
  - REQ: irq = 1.
    - vector tracks sel each cycle, so a higher-priority arrival pre-empts before acknowledge.
    - If eligible becomes 0 (masked or cleared), return to IDLE; irq drops the following cycle.
    - On irq_ack: clear pending[vector], freeze vector, go to SERVICE.
  - SERVICE: irq = 0, in_service = 1.
    - Stays here until a write to EOI, then returns to IDLE.
    - Further edges set pending but are not presented.
- irq_ack outside REQ is ignored (no state or pending change).
- Simultaneous clear and new edge on the same bit in one cycle: the set wins and the bit stays pending.
- Registers:
  - PEND read returns pending zero-extended to 16 bits. Writing PEND clears the bits written as 1 (W1C).
  - MASK is read/write over bits [N_SRC-1:0]; upper bits read 0 and writes to them are ignored.
  - VEC read returns {in_service, 0..., vector}, with in_service at bit 15. Writes to VEC are ignored.
  - EOI read returns 0. Any write to EOI in SERVICE ends service. A write to EOI in another state has no effect.
- Latency:
  - Source edge to irq high is 2 cycles (capture, then IDLE->REQ), provided the source is enabled and the controller is idle.
  - irq_ack to irq low is 1 cycle.
- Reset mid-operation: returns to the reset values on the next edge, clears all pending, and drops irq in the same cycle it registers.

Optional Feature:
- Macro: IRQ_CONTROLLER_LEVEL_EN.
- When defined:
  - Sources are level-sensitive: pending[i] = src_irq[i] every cycle.
  - PEND writes are ignored.
  - The acknowledge does not clear pending; the driver must deassert.
  - In SERVICE, EOI with the source still high re-enters REQ via IDLE.
- When undefined: edge capture as above.

Test Plan:
- Reset, then mask = 0x3 and a pulse on src_irq[1] -> irq=1 two cycles after the edge, vector=1; irq_ack -> irq=0 next cycle, in_service=1, PEND reads 0x0; EOI write -> state IDLE, in_service=0.
- Masked source: mask = 0x1, pulse src_irq[2] -> irq stays 0, PEND = 0x4; then write mask = 0x5 -> irq=1 two cycles later, vector=2.
- Pre-emption: in REQ with vector=2, pulse src_irq[0] -> vector=0 before ack; ack clears only bit 0; after EOI -> REQ again with vector=2.
- Edge during SERVICE plus same-cycle W1C to PEND of that bit -> bit remains set (PEND shows it); irq stays 0 until EOI.
- Stray ack in IDLE, and EOI write in REQ -> no change in irq, vector or pending; assert reset in REQ -> irq=0, PEND=0, MASK=0.
- With IRQ_CONTROLLER_LEVEL_EN: hold src_irq[3] high, mask = 0x8, ack, then EOI -> irq reasserts (vector=3); drop the source -> no further request.
